// File: rtl/regfile_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_if
// Bundles the two requester handshakes (A = ALU writeback, B = memory-load
// writeback) and the register-file write port driven by the arbiter.
//   a_valid/a_ready/a_reg/a_data : requester A push channel
//   b_valid/b_ready/b_reg/b_data : requester B push channel
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg : registered write port
//   grant_a/grant_b : registered source of the current output slot
//   busy            : either requester FIFO holds an entry
// master = requester/register-file side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  a_valid;
    logic                  a_ready;
    logic [ADDR_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] a_data;

    logic                  b_valid;
    logic                  b_ready;
    logic [ADDR_WIDTH-1:0] b_reg;
    logic [DATA_WIDTH-1:0] b_data;

    logic                  ctrl_writeEnable;
    logic [ADDR_WIDTH-1:0] ctrl_writeReg;
    logic [DATA_WIDTH-1:0] data_writeReg;
    logic                  grant_a;
    logic                  grant_b;
    logic                  busy;

    modport master (
        output a_valid, a_reg, a_data,
        output b_valid, b_reg, b_data,
        input  a_ready, b_ready,
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  grant_a, grant_b, busy
    );

    modport slave (
        input  a_valid, a_reg, a_data,
        input  b_valid, b_reg, b_data,
        output a_ready, b_ready,
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output grant_a, grant_b, busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the single register-file write port between requester A and
// requester B. Each requester pushes (register, data) pairs into its own
// FIFO_DEPTH-entry circular FIFO; a round-robin arbiter pops at most one head
// per cycle into a registered write port. Writes to r0 are consumed (grant
// pulses) but the write strobe stays low.
// Ports:
//   clock      : rising-edge system clock
//   ctrl_reset : synchronous active-high reset
//   bus        : slave side of regfile_write_arbiter_if (both push channels,
//                write port, grants, busy)
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clock,
    input  logic                    ctrl_reset,
    regfile_write_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] dst;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    // Index 0 = requester A, index 1 = requester B throughout.
    entry_t           mem_q    [2][FIFO_DEPTH];
    entry_t           mem_d    [2][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [2];
    logic [PTR_W-1:0] wr_ptr_d [2];
    logic [PTR_W-1:0] rd_ptr_q [2];
    logic [PTR_W-1:0] rd_ptr_d [2];
    logic [CNT_W-1:0] count_q  [2];
    logic [CNT_W-1:0] count_d  [2];

    src_e                  last_grant_q, last_grant_d;
    logic                  write_en_q,   write_en_d;
    logic [ADDR_WIDTH-1:0] write_reg_q,  write_reg_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic                  grant_a_q,    grant_a_d;
    logic                  grant_b_q,    grant_b_d;

    logic   in_valid  [2];
    entry_t in_entry  [2];
    logic   ready     [2];
    logic   push      [2];
    logic   non_empty [2];
    logic   pop       [2];
    logic   pop_valid;
    src_e   pop_src;
    logic   pop_idx;
    entry_t head;

    // Push side: ready is a function of the stored count only, so a full FIFO
    // refuses a push even when it is being popped in the same cycle.
    always_comb begin
        in_valid[0] = bus.a_valid;
        in_valid[1] = bus.b_valid;
        in_entry[0] = '{dst: bus.a_reg, data: bus.a_data};
        in_entry[1] = '{dst: bus.b_reg, data: bus.b_data};
        for (int i = 0; i < 2; i++) begin
            ready[i]     = (count_q[i] != CNT_W'(FIFO_DEPTH));
            push[i]      = in_valid[i] && ready[i];
            non_empty[i] = (count_q[i] != '0);
        end
    end

    // Round-robin on FIFO heads: a tie goes to the source that did not win
    // last time. Decided from stored counts, so a fresh push is never popped
    // in its own cycle.
    always_comb begin
        pop_valid = 1'b0;
        pop_src   = SRC_A;
        if (non_empty[0] && non_empty[1]) begin
            pop_valid = 1'b1;
            pop_src   = (last_grant_q == SRC_A) ? SRC_B : SRC_A;
        end else if (non_empty[0]) begin
            pop_valid = 1'b1;
            pop_src   = SRC_A;
        end else if (non_empty[1]) begin
            pop_valid = 1'b1;
            pop_src   = SRC_B;
        end
        pop_idx = (pop_src == SRC_B);
        pop[0]  = pop_valid && (pop_src == SRC_A);
        pop[1]  = pop_valid && (pop_src == SRC_B);
        head    = mem_q[pop_idx][rd_ptr_q[pop_idx]];
    end

    // Next-state logic for FIFOs, arbiter history and the output register.
    // NOTE: every variable gets its hold value first so no path through the
    // block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        last_grant_d  = last_grant_q;
        write_en_d    = 1'b0;
        grant_a_d     = 1'b0;
        grant_b_d     = 1'b0;
        write_reg_d   = write_reg_q;
        write_data_d  = write_data_q;

        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_entry[i];
                // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase
        end

        if (pop_valid) begin
            last_grant_d = pop_src;
            write_reg_d  = head.dst;
            write_data_d = head.data;
            // r0 is hardwired zero: the entry is consumed but never written.
            write_en_d   = (head.dst != '0);
            grant_a_d    = (pop_src == SRC_A);
            grant_b_d    = (pop_src == SRC_B);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            last_grant_q <= SRC_B;
            write_en_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            grant_a_q    <= 1'b0;
            grant_b_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            write_en_q   <= write_en_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            grant_a_q    <= grant_a_d;
            grant_b_q    <= grant_b_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; an entry is only ever read
    // after it has been written, because count gates every pop.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign bus.a_ready          = ready[0];
    assign bus.b_ready          = ready[1];
    assign bus.busy             = non_empty[0] || non_empty[1];
    assign bus.ctrl_writeEnable = write_en_q;
    assign bus.ctrl_writeReg    = write_reg_q;
    assign bus.data_writeReg    = write_data_q;
    assign bus.grant_a          = grant_a_q;
    assign bus.grant_b          = grant_b_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Scoreboard bench. The stimulus process keeps a queue-based model of both
// requester FIFOs and the round-robin rule; every predicted write-port slot is
// pushed into exp_q tagged with the clock edge it must appear after. A monitor
// on the falling edge pops and compares whenever that slot is due, and
// otherwise expects an idle write port holding its last index/data.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    typedef struct {
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        int            cyc;
        bit            src_b;
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
    } exp_t;

    logic clock;
    logic ctrl_reset;

    regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    regfile_write_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int   n_vec = 0;
    int   n_err = 0;
    ent_t qa[$];
    ent_t qb[$];
    exp_t exp_q[$];
    bit   last_b  = 1'b1;
    bit   mon_en  = 1'b0;
    int   rst_cyc = -1;
    logic [AW-1:0] hold_reg;
    logic [DW-1:0] hold_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock of stimulus. Inputs are driven 1 time unit after a rising
    // edge; the model decides the pop for the upcoming edge from the queue
    // contents before this cycle's pushes.
    task automatic step(input bit rst,
                        input bit av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                        input bit bv, input logic [AW-1:0] br, input logic [DW-1:0] bd,
                        output bit acc_a, output bit acc_b);
        bit   rdy_a, rdy_b, ne_a, ne_b, pa, pb;
        exp_t e;
        ent_t h;
        ctrl_reset  = rst;
        bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
        bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
        rdy_a = (qa.size() < DEPTH);
        rdy_b = (qb.size() < DEPTH);
        ne_a  = (qa.size() != 0);
        ne_b  = (qb.size() != 0);
        #1;
        if (mon_en) begin
            check("a_ready", bus.a_ready, rdy_a);
            check("b_ready", bus.b_ready, rdy_b);
            check("busy", bus.busy, ne_a || ne_b);
        end
        acc_a = !rst && av && rdy_a;
        acc_b = !rst && bv && rdy_b;
        if (rst) begin
            qa.delete();
            qb.delete();
            last_b  = 1'b1;
            rst_cyc = cyc + 1;
        end else begin
            pa = ne_a && (!ne_b || last_b);
            pb = ne_b && !pa;
            if (pa) begin
                h = qa.pop_front();
                e = '{cyc: cyc + 1, src_b: 1'b0, dst: h.dst, data: h.data};
                exp_q.push_back(e);
                last_b = 1'b0;
            end else if (pb) begin
                h = qb.pop_front();
                e = '{cyc: cyc + 1, src_b: 1'b1, dst: h.dst, data: h.data};
                exp_q.push_back(e);
                last_b = 1'b1;
            end
            if (acc_a) qa.push_back('{dst: ar, data: ad});
            if (acc_b) qb.push_back('{dst: br, data: bd});
        end
        @(posedge clock);
        #1;
        if (rst) mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        bit xa, xb;
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0, xa, xb);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            if (cyc == rst_cyc) begin
                hold_reg  = '0;
                hold_data = '0;
            end
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("grant_a", bus.grant_a, !e.src_b);
                check("grant_b", bus.grant_b, e.src_b);
                check("write_enable", bus.ctrl_writeEnable, e.dst != '0);
                check("write_reg", bus.ctrl_writeReg, e.dst);
                check("write_data", bus.data_writeReg, e.data);
                hold_reg  = e.dst;
                hold_data = e.data;
            end else begin
                check("idle_grant_a", bus.grant_a, 1'b0);
                check("idle_grant_b", bus.grant_b, 1'b0);
                check("idle_write_enable", bus.ctrl_writeEnable, 1'b0);
                check("idle_write_reg_hold", bus.ctrl_writeReg, hold_reg);
                check("idle_write_data_hold", bus.data_writeReg, hold_data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit acc_a, acc_b, got;
        ctrl_reset = 1'b1;
        bus.a_valid = 1'b0; bus.a_reg = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_reg = '0; bus.b_data = '0;

        // Reset, then a single A write to r5.
        step(1, 0, '0, '0, 0, '0, '0, acc_a, acc_b);
        step(1, 0, '0, '0, 0, '0, '0, acc_a, acc_b);
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0, acc_a, acc_b);
        check("single_push_accepted", acc_a, 1'b1);
        idle(3);

        // Simultaneous pushes every cycle from a fresh reset: A wins first tie.
        step(1, 0, '0, '0, 0, '0, '0, acc_a, acc_b);
        for (int i = 0; i < 8; i++)
            step(0, 1, 5'd1, DW'(i), 1, 5'd2, DW'(100 + i), acc_a, acc_b);
        idle(5);

        // A held valid until accepted; B kept busy so A's FIFO fills and wraps.
        for (int k = 0; k < 12; k++) begin
            got = 1'b0;
            for (int t = 0; t < 8 && !got; t++) begin
                step(0, 1, 5'd3, 32'h3000 + k, 1, 5'd4, 32'h4000 + DW'(k * 8 + t), acc_a, acc_b);
                got = acc_a;
            end
            check("a_held_valid_accepted", got, 1'b1);
        end
        idle(6);

        // r0 write from B: grant pulses, no write strobe, busy clears.
        step(0, 0, '0, '0, 1, 5'd0, 32'h1234, acc_a, acc_b);
        idle(3);

        // Make last_grant = B, then both sources target r7 in the same cycle.
        step(0, 0, '0, '0, 1, 5'd9, 32'h99, acc_a, acc_b);
        idle(2);
        step(0, 1, 5'd7, 32'hAA, 1, 5'd7, 32'hBB, acc_a, acc_b);
        idle(4);

        // Fill both FIFOs, reset with entries in flight, then a tie (A first).
        for (int i = 0; i < 4; i++)
            step(0, 1, 5'd10, 32'hA0 + i, 1, 5'd11, 32'hB0 + i, acc_a, acc_b);
        step(1, 1, 5'd12, 32'hEE, 1, 5'd13, 32'hFF, acc_a, acc_b);
        step(0, 1, 5'd14, 32'hC0, 1, 5'd15, 32'hD0, acc_a, acc_b);
        idle(4);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
            rb = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) != 0, ra, $urandom,
                 $urandom_range(0, 2) != 0, rb, $urandom,
                 acc_a, acc_b);
        end
        idle(8);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32x32 register file between two result sources: A (ALU writeback) and B (memory-load writeback). Each source pushes (register, data) pairs through a valid/ready handshake into its own small FIFO. A round-robin arbiter pops at most one entry per cycle and drives registered ctrl_writeEnable, ctrl_writeReg and data_writeReg straight into the register file. Writes to register 0 are consumed but suppressed, so r0 stays zero.

Parameters:
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, width of register index
FIFO_DEPTH, 2, entries per requester FIFO (power of 2, >=2)

Ports:
clock  in  1  single system clock, all state on rising edge
ctrl_reset  in  1  synchronous, active-high reset
a_valid  in  1  requester A offers a write
a_ready  out  1  FIFO A can accept (not full)
a_reg  in  ADDR_WIDTH  A destination register
a_data  in  DATA_WIDTH  A write data
b_valid  in  1  requester B offers a write
b_ready  out  1  FIFO B can accept (not full)
b_reg  in  ADDR_WIDTH  B destination register
b_data  in  DATA_WIDTH  B write data
ctrl_writeEnable  out  1  registered write strobe to register file
ctrl_writeReg  out  ADDR_WIDTH  registered write index
data_writeReg  out  DATA_WIDTH  registered write data
grant_a  out  1  registered: current output slot came from A
grant_b  out  1  registered: current output slot came from B
busy  out  1  either FIFO non-empty

Behaviour:
- Reset (ctrl_reset=1 at edge): both FIFOs emptied (pointers and counts = 0), ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, grant_a=grant_b=0, last_grant=B. Synchronous reset overrides all pushes and pops in that cycle. In-flight contents are discarded.
- Handshake: a push occurs when valid && ready at an edge. a_ready = !fullA, and likewise for B. ready depends only on the FIFO count, not on a same-cycle pop, so a full FIFO deasserts ready even if it is popped that cycle. Data and reg are sampled at the push edge. valid while !ready has no effect.
- FIFO: circular buffer of FIFO_DEPTH entries with wrap-around read/write pointers and count 0..FIFO_DEPTH. A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged. A push into an empty FIFO cannot be popped in the same cycle (no bypass).
- Arbitration (combinational on FIFO heads, once per cycle):
  - Neither non-empty: no pop.
  - Only one non-empty: pop that one.
  - Both non-empty: pop the one not equal to last_grant.
  - On every pop, last_grant is updated to the popped source.
- Output register, loaded at every edge:
  - On a pop: ctrl_writeReg=head.reg, data_writeReg=head.data, grant_x=1 for the popped source, ctrl_writeEnable = (head.reg != 0).
  - With no pop: ctrl_writeEnable=0, grant_a=grant_b=0, ctrl_writeReg and data_writeReg hold their previous values.
- Latency: a push at edge E0 into an empty FIFO with no contention gives outputs valid from edge E1 to E2, so the register file writes at E2.
- Throughput: one write per cycle total. Under continuous contention A and B alternate strictly.
- Register 0: the entry is popped and its grant_x pulses, but ctrl_writeEnable stays 0.
- Same destination from both sources: writes occur in grant order, and the later grant's data is final. No merging or reordering within a source; each FIFO is strictly in order.
- busy = countA!=0 || countB!=0 (combinational from state).

Test Plan:
1. Reset, then a_valid=1, a_reg=5, a_data=0xDEADBEEF for one cycle -> a_ready=1 at push; one cycle later ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF, grant_a=1; the following cycle ctrl_writeEnable=0.
2. A and B push simultaneously every cycle (A reg=1 data=i, B reg=2 data=100+i) -> first write from A, then strictly alternating B, A, B. No entry is lost and each source's data sequence stays in order.
3. Fill FIFO A (two pushes) while B is also kept non-empty -> a_ready=0 while countA=2; an a_valid held high is not accepted until the count drops. Pointer wrap is verified over 10+ pushes.
4. Push b_reg=0, b_data=0x1234 -> grant_b=1 pulses, ctrl_writeEnable=0, FIFO B empties, busy returns to 0.
5. A and B both target reg 7 (A data=0xAA, B data=0xBB) in the same cycle, with last_grant=B -> write order is A then B; 0xBB is the final write.
6. Assert ctrl_reset for one cycle with both FIFOs holding 2 entries -> next cycle busy=0, ctrl_writeEnable=0, grants=0, a_ready=b_ready=1. No stale entries are written afterward; the first post-reset tie goes to A.
